// File: rtl/sys_clkgen_div.sv
// -----------------------------------------------------------------------------
// sys_clkgen_div
//   Programmable clock divider with edge strobes and a wait-cycle engine that
//   counts periods of the divided clock.
//
//   Ports
//     Clk        in   system clock, all logic on its rising edge
//     Rst        in   synchronous active-high reset
//     En         in   run the divided clock while high
//     Div        in   requested divisor (ClkOut period in Clk cycles)
//     DivLoad    in   strobe: capture Div into the pending divisor
//     ClkOut     out  registered divided clock
//     Tick       out  pulse on the first high cycle of each ClkOut period
//     TickFall   out  pulse on the first low cycle after a high phase
//     Running    out  divider state machine is not idle
//     WaitStart  in   strobe: start a wait of WaitCycles Ticks
//     WaitCycles in   number of Ticks to wait
//     WaitBusy   out  wait in progress
//     WaitDone   out  pulse when a wait completes
// -----------------------------------------------------------------------------
module sys_clkgen_div #(
    parameter int DIV_W       = 16,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 500
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic [DIV_W-1:0] Div,
    input  logic             DivLoad,
    output logic             ClkOut,
    output logic             Tick,
    output logic             TickFall,
    output logic             Running,
    input  logic             WaitStart,
    input  logic [CNT_W-1:0] WaitCycles,
    output logic             WaitBusy,
    output logic             WaitDone
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] LP_DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] LP_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] LP_TWO     = DIV_W'(2);
    localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

    // Divisors below 2 cannot form a high and a low phase; treat them as 2.
    function automatic logic [DIV_W-1:0] f_clamp_div(input logic [DIV_W-1:0] d);
        f_clamp_div = (d < LP_TWO) ? LP_TWO : d;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_phase;
    logic [DIV_W-1:0] w_phase_nxt;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] w_div_act_nxt;
    logic [DIV_W-1:0] r_div_pend;
    logic             r_clk_out;
    logic             w_clk_out_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_tick_fall;
    logic             w_tick_fall_nxt;

    logic             r_wait_busy;
    logic             r_wait_done;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_dec;

    // Phase lengths. The active divisor is stored already clamped; the pending
    // one is clamped as it is promoted at a period boundary. Hi >= 1 always,
    // so Hi-1 and Lo-1 never underflow, and D - floor(D/2) cannot overflow.
    logic [DIV_W-1:0] w_pend_div;
    logic [DIV_W-1:0] w_pend_hi;
    logic [DIV_W-1:0] w_act_lo;

    assign w_pend_div = f_clamp_div(r_div_pend);
    assign w_pend_hi  = w_pend_div >> 1;
    assign w_act_lo   = r_div_act - (r_div_act >> 1);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_div_act   <= LP_DEF_DIV;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
            r_tick_fall <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_div_act   <= w_div_act_nxt;
            r_clk_out   <= w_clk_out_nxt;
            r_tick      <= w_tick_nxt;
            r_tick_fall <= w_tick_fall_nxt;
        end
    end

    // A load coinciding with a boundary lands here after the boundary has
    // already promoted the old pending value, so it waits one more period.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_div_pend <= LP_DEF_DIV;
        end else if (DivLoad) begin
            r_div_pend <= Div;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_div_act_nxt   = r_div_act;
        w_clk_out_nxt   = r_clk_out;
        w_tick_nxt      = 1'b0;
        w_tick_fall_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clk_out_nxt = 1'b0;
                if (En) begin
                    w_state_nxt   = ST_HIGH;
                    w_clk_out_nxt = 1'b1;
                    w_tick_nxt    = 1'b1;
                    w_div_act_nxt = w_pend_div;
                    w_phase_nxt   = w_pend_hi - LP_ONE;
                end
            end
            ST_HIGH: begin
                // En is not looked at: a started high phase always completes.
                if (r_phase == '0) begin
                    w_state_nxt     = ST_LOW;
                    w_clk_out_nxt   = 1'b0;
                    w_tick_fall_nxt = 1'b1;
                    w_phase_nxt     = w_act_lo - LP_ONE;
                end else begin
                    w_phase_nxt = r_phase - LP_ONE;
                end
            end
            ST_LOW: begin
                if (r_phase == '0) begin
                    if (En) begin
                        w_state_nxt   = ST_HIGH;
                        w_clk_out_nxt = 1'b1;
                        w_tick_nxt    = 1'b1;
                        w_div_act_nxt = w_pend_div;
                        w_phase_nxt   = w_pend_hi - LP_ONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_phase_nxt = '0;
                    end
                end else begin
                    w_phase_nxt = r_phase - LP_ONE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_phase_nxt   = '0;
                w_clk_out_nxt = 1'b0;
            end
        endcase
    end

    // Wait engine. WaitStart has priority over a Tick in the same cycle, so
    // that Tick is not counted against the new wait.
    assign w_wait_cnt_dec = r_wait_cnt - LP_CNT_ONE;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wait_busy <= 1'b0;
            r_wait_done <= 1'b0;
            r_wait_cnt  <= '0;
        end else if (WaitStart) begin
            if (WaitCycles != '0) begin
                r_wait_busy <= 1'b1;
                r_wait_done <= 1'b0;
                r_wait_cnt  <= WaitCycles;
            end else begin
                r_wait_busy <= 1'b0;
                r_wait_done <= 1'b1;
                r_wait_cnt  <= '0;
            end
        end else if (r_wait_busy && r_tick) begin
            r_wait_cnt <= w_wait_cnt_dec;
            if (w_wait_cnt_dec == '0) begin
                r_wait_busy <= 1'b0;
                r_wait_done <= 1'b1;
            end else begin
                r_wait_done <= 1'b0;
            end
        end else begin
            r_wait_done <= 1'b0;
        end
    end

    assign ClkOut   = r_clk_out;
    assign Tick     = r_tick;
    assign TickFall = r_tick_fall;
    assign Running  = (r_state != ST_IDLE);
    assign WaitBusy = r_wait_busy;
    assign WaitDone = r_wait_done;

endmodule

// File: tb/tb_sys_clkgen_div.sv
// Bench for sys_clkgen_div: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a period-position model.
module tb_sys_clkgen_div;

    localparam int DIV_W       = 16;
    localparam int CNT_W       = 32;
    localparam int DEFAULT_DIV = 500;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             En;
    logic [DIV_W-1:0] Div;
    logic             DivLoad;
    logic             WaitStart;
    logic [CNT_W-1:0] WaitCycles;
    logic             ClkOut;
    logic             Tick;
    logic             TickFall;
    logic             Running;
    logic             WaitBusy;
    logic             WaitDone;

    sys_clkgen_div #(
        .DIV_W      (DIV_W),
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .En        (En),
        .Div       (Div),
        .DivLoad   (DivLoad),
        .ClkOut    (ClkOut),
        .Tick      (Tick),
        .TickFall  (TickFall),
        .Running   (Running),
        .WaitStart (WaitStart),
        .WaitCycles(WaitCycles),
        .WaitBusy  (WaitBusy),
        .WaitDone  (WaitDone)
    );

    always #10 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The divided clock is described by its position inside the current period
    // (0..D-1): high for the first floor(D/2) positions, low for the rest.
    bit     m_run  = 1'b0;
    int     m_pos  = 0;
    int     m_d    = DEFAULT_DIV;
    int     m_pend = DEFAULT_DIV;
    bit     m_busy = 1'b0;
    bit     m_done = 1'b0;
    longint m_rem  = 0;
    bit     m_tick;

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    always @(posedge Clk) begin
        m_tick = m_run && (m_pos == 0);
        if (Rst) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_d    = DEFAULT_DIV;
            m_pend = DEFAULT_DIV;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_rem  = 0;
        end else begin
            // wait engine: Ticks remaining until completion
            m_done = 1'b0;
            if (WaitStart) begin
                m_rem  = WaitCycles;
                m_busy = (WaitCycles != 0);
                m_done = (WaitCycles == 0);
            end else if (m_busy && m_tick) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            // divided clock: periods start only at boundaries, using the
            // pending divisor as it stood before this edge
            if (!m_run) begin
                if (En) begin
                    m_run = 1'b1;
                    m_pos = 0;
                    m_d   = clampd(m_pend);
                end
            end else if (m_pos == m_d - 1) begin
                if (En) begin
                    m_pos = 0;
                    m_d   = clampd(m_pend);
                end else begin
                    m_run = 1'b0;
                    m_pos = 0;
                end
            end else begin
                m_pos = m_pos + 1;
            end
            if (DivLoad) m_pend = Div;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("ClkOut",   ClkOut,   m_run && (m_pos < m_d / 2));
            chk("Tick",     Tick,     m_run && (m_pos == 0));
            chk("TickFall", TickFall, m_run && (m_pos == m_d / 2));
            chk("Running",  Running,  m_run);
            chk("WaitBusy", WaitBusy, m_busy);
            chk("WaitDone", WaitDone, m_done);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge Clk);
    endtask

    task automatic load_div(input int d);
        Div     = DIV_W'(d);
        DivLoad = 1'b1;
        step();
        DivLoad = 1'b0;
    endtask

    task automatic wait_idle();
        En = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!Running) return;
            step();
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    // Leaves the bench at the first high cycle of a fresh period.
    task automatic start_div(input int d);
        wait_idle();
        load_div(d);
        En = 1'b1;
        step();
    endtask

    int  v;
    int  tv;
    int  nt;
    int  nf;
    int  nd;
    int  ncyc;
    int  nbusy;
    bit  found;
    bit  prevtick;
    bit  dprev;

    initial begin
        Rst = 1'b1; En = 1'b0; Div = '0; DivLoad = 1'b0;
        WaitStart = 1'b0; WaitCycles = '0;
        step();
        step();
        chk_en = 1'b1;
        Rst = 1'b0;
        // reset state
        chk("rst_ClkOut",   ClkOut,   0);
        chk("rst_Running",  Running,  0);
        chk("rst_Tick",     Tick,     0);
        chk("rst_WaitBusy", WaitBusy, 0);
        chk("rst_WaitDone", WaitDone, 0);

        // default divisor: 250 high / 250 low, Tick every 500, 1-cycle start
        En = 1'b1;
        step();
        chk("def_first_tick", Tick, 1);
        chk("def_first_high", ClkOut, 1);
        v = 0; nt = 0;
        for (int i = 0; i < 500; i++) begin
            v += int'(ClkOut);
            nt += int'(Tick);
            step();
        end
        chk("def_high_cycles", v, 250);
        chk("def_ticks_in_period", nt, 1);
        chk("def_second_tick", Tick, 1);

        // Div=5 -> 1,1,0,0,0
        start_div(5);
        v = 0; nt = 0; nf = 0;
        for (int i = 0; i < 10; i++) begin
            v = (v << 1) | int'(ClkOut);
            nt += int'(Tick);
            nf += int'(TickFall);
            step();
        end
        chk("div5_pattern", v, 'b1100011000);
        chk("div5_ticks", nt, 2);
        chk("div5_tickfalls", nf, 2);

        // Div=0 and Div=1 clamp to 2
        for (int d = 0; d < 2; d++) begin
            start_div(d);
            v = 0;
            for (int i = 0; i < 6; i++) begin
                v = (v << 1) | int'(ClkOut);
                step();
            end
            chk($sformatf("div%0d_pattern", d), v, 'b101010);
        end

        // Div=4 running, load 8 in the high phase: 4-cycle period then 8
        start_div(4);
        v = int'(ClkOut);
        Div = DIV_W'(8);
        DivLoad = 1'b1;
        step();
        DivLoad = 1'b0;
        for (int i = 1; i < 12; i++) begin
            v = (v << 1) | int'(ClkOut);
            step();
        end
        chk("div4to8_pattern", v, 'b110011110000);

        // Div=6, drop En in high phase: period completes then idle
        start_div(6);
        En = 1'b0;
        v = 0;
        for (int i = 0; i < 6; i++) begin
            v = (v << 1) | int'(ClkOut);
            step();
        end
        chk("div6_stop_pattern", v, 'b111000);
        chk("div6_stop_running", Running, 0);
        chk("div6_stop_clkout", ClkOut, 0);

        // Div=6, drop En in high phase, re-raise during low: seamless
        start_div(6);
        En = 1'b0;
        v = 0; tv = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) En = 1'b1;
            v  = (v << 1) | int'(ClkOut);
            tv = (tv << 1) | int'(Tick);
            step();
        end
        chk("div6_resume_pattern", v, 'b111000111000);
        chk("div6_resume_ticks", tv, 'b100000100000);

        // Wait N=3 at Div=4, started on a Tick cycle (that Tick not counted)
        start_div(4);
        WaitCycles = 3;
        WaitStart = 1'b1;
        step();
        WaitStart = 1'b0;
        nt = 0; nbusy = 0; ncyc = 0; found = 1'b0; prevtick = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (WaitDone) begin
                found = 1'b1;
                break;
            end
            nt += int'(Tick);
            nbusy += int'(WaitBusy);
            ncyc++;
            prevtick = Tick;
            step();
        end
        chk("wait3_done_seen", found, 1);
        chk("wait3_ticks", nt, 3);
        chk("wait3_done_after_tick", prevtick, 1);
        chk("wait3_busy_span", nbusy, ncyc);
        chk("wait3_span_cycles", ncyc, 12);
        chk("wait3_busy_at_done", WaitBusy, 0);

        // N=0: done next cycle, never busy
        WaitCycles = 0;
        WaitStart = 1'b1;
        step();
        WaitStart = 1'b0;
        chk("wait0_done", WaitDone, 1);
        chk("wait0_busy", WaitBusy, 0);
        step();
        chk("wait0_done_pulse", WaitDone, 0);

        // Restart N=5 with N=1 after two Ticks: a single WaitDone
        WaitCycles = 5;
        WaitStart = 1'b1;
        step();
        WaitStart = 1'b0;
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            if (Tick) nt++;
            if (nt == 2) break;
            step();
        end
        chk("restart_two_ticks", nt, 2);
        step();
        WaitCycles = 1;
        WaitStart = 1'b1;
        step();
        WaitStart = 1'b0;
        nd = 0; dprev = 1'b0; prevtick = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (WaitDone) begin
                nd++;
                dprev = prevtick;
            end
            prevtick = Tick;
            step();
        end
        chk("restart_done_count", nd, 1);
        chk("restart_done_after_tick", dprev, 1);

        // Reset mid-wait
        WaitCycles = 5;
        WaitStart = 1'b1;
        step();
        WaitStart = 1'b0;
        step();
        step();
        Rst = 1'b1;
        step();
        chk("rst_mid_ClkOut",   ClkOut,   0);
        chk("rst_mid_Tick",     Tick,     0);
        chk("rst_mid_TickFall", TickFall, 0);
        chk("rst_mid_Running",  Running,  0);
        chk("rst_mid_WaitBusy", WaitBusy, 0);
        chk("rst_mid_WaitDone", WaitDone, 0);
        Rst = 1'b0;
        En = 1'b0;
        step();

        // Randomized traffic against the model
        for (int it = 0; it < 6000; it++) begin
            En        = ($urandom % 8) != 0;
            DivLoad   = ($urandom % 10) == 0;
            Div       = (($urandom % 4) == 0) ? DIV_W'($urandom_range(0, 40))
                                              : DIV_W'($urandom_range(0, 9));
            WaitStart = ($urandom % 12) == 0;
            WaitCycles = CNT_W'($urandom_range(0, 4));
            Rst       = ($urandom % 700) == 0;
            step();
        end
        En = 1'b0; DivLoad = 1'b0; WaitStart = 1'b0; Rst = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
